// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 matrix keypad one column at a time, debounces key presses and
// releases, and shifts each accepted key's hex value into a 4-digit number.
//
// Parameters
//   SCAN_DIV     : cycles each column is driven before its rows are sampled (>= 4)
//   DEBOUNCE_CNT : consecutive stable cycles to accept a press or a release (>= 2)
//   REPEAT_CNT   : cycles between auto-repeat events (auto-repeat builds only, >= 2)
//
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   row       in   4  keypad rows, active-low, asynchronous to clk
//   col       out  4  keypad columns, active-low, exactly one bit low
//   clear     in   1  synchronous clear of number (wins over a same-edge event)
//   number    out 16  entered hex digits, newest in [3:0]
//   key_code  out  4  hex value of the last accepted key
//   key_valid out  1  one-cycle pulse per accepted key event
//
// Build option
//   KEYPAD_AUTOREPEAT_EN : when defined, a held key produces a further event
//                          every REPEAT_CNT cycles. When undefined, exactly one
//                          event per press and no repeat logic exists.
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 1000000,
   parameter int REPEAT_CNT   = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        clear,
   output logic [15:0] number,
   output logic [3:0]  key_code,
   output logic        key_valid
);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;

   // Counters only ever count up to their terminal value, so N-1 must fit.
   localparam int SW = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = ($clog2(DEBOUNCE_CNT) > 0) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

   // ---------------------------------------------------------------------------
   // Row synchronizer; every decision below looks at row_s only.
   // Reset value is "no key" so nothing is seen while reset is released.
   // ---------------------------------------------------------------------------
   logic [3:0] row_m, row_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_m <= 4'hF;
         row_s <= 4'hF;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   // Exactly one low row bit is a valid single key; anything else (no key or
   // several keys in the same column) is treated as no key.
   logic       one_low;
   logic [1:0] low_idx;

   always_comb begin
      one_low = 1'b1;
      low_idx = 2'd0;
      case (row_s)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   // Physical key layout, indexed by {row index, column index}.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = 4'hA;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = 4'h0;
         4'hD: k = 4'hF;
         4'hE: k = 4'hE;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // ---------------------------------------------------------------------------
   // Scan / debounce FSM
   // ---------------------------------------------------------------------------
   logic [1:0]    state, state_d;
   logic [1:0]    col_idx, col_idx_d;
   logic [1:0]    row_idx, row_idx_d;
   logic [3:0]    row_lat, row_lat_d;
   logic [SW-1:0] scnt, scnt_d;
   logic [DW-1:0] dcnt, dcnt_d;
   logic          accept;
   logic          evt;
   logic [3:0]    cur_code;

   always_comb begin
      state_d   = state;
      col_idx_d = col_idx;
      row_idx_d = row_idx;
      row_lat_d = row_lat;
      scnt_d    = scnt;
      dcnt_d    = dcnt;
      accept    = 1'b0;
      case (state)
         SCAN: begin
            // Sample on the last dwell cycle so the synchronizer has caught
            // up with the newly driven column.
            if (scnt == SCAN_LAST) begin
               scnt_d = '0;
               dcnt_d = '0;
               if (one_low) begin
                  state_d   = DEBOUNCE;
                  row_lat_d = row_s;
                  row_idx_d = low_idx;
               end else begin
                  col_idx_d = col_idx + 2'd1;
               end
            end else begin
               scnt_d = scnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (row_s != row_lat) begin
               state_d   = SCAN;
               col_idx_d = col_idx + 2'd1;
               dcnt_d    = '0;
            end else if (dcnt == DEB_LAST) begin
               state_d = HELD;
               dcnt_d  = '0;
               accept  = 1'b1;
            end else begin
               dcnt_d = dcnt + 1'b1;
            end
         end
         HELD: begin
            // Release needs an unbroken run of all-high samples; any low bit
            // restarts it. Column stays frozen until then.
            if (row_s != 4'hF) begin
               dcnt_d = '0;
            end else if (dcnt == DEB_LAST) begin
               state_d   = SCAN;
               col_idx_d = col_idx + 2'd1;
               dcnt_d    = '0;
            end else begin
               dcnt_d = dcnt + 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
            scnt_d  = '0;
            dcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SCAN;
         col_idx <= 2'd0;
         row_idx <= 2'd0;
         row_lat <= 4'hF;
         scnt    <= '0;
         dcnt    <= '0;
      end else begin
         state   <= state_d;
         col_idx <= col_idx_d;
         row_idx <= row_idx_d;
         row_lat <= row_lat_d;
         scnt    <= scnt_d;
         dcnt    <= dcnt_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // ---------------------------------------------------------------------------
   // Auto-repeat: while HELD and the latched key is still read, fire a further
   // event every REPEAT_CNT cycles. Leaving HELD (release) discards the count.
   // A repeat needs row_s == row_lat and a release needs row_s == F, so the two
   // can never land on the same edge.
   // ---------------------------------------------------------------------------
   localparam int RW = ($clog2(REPEAT_CNT) > 0) ? $clog2(REPEAT_CNT) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CNT - 1);

   logic [RW-1:0] rcnt;
   logic          rpt_evt;

   assign rpt_evt = (state == HELD) && (row_s == row_lat) && (rcnt == RPT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rcnt <= '0;
      else if (state != HELD || rpt_evt)
         rcnt <= '0;
      else if (row_s == row_lat)
         rcnt <= rcnt + 1'b1;
   end

   assign evt = accept | rpt_evt;
`else
   assign evt = accept;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cur_code = key_map(row_idx, col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         number    <= 16'h0000;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= evt;
         if (evt)
            key_code <= cur_code;
         // clear wins over a same-edge event for number only
         if (clear)
            number <= 16'h0000;
         else if (evt)
            number <= {number[11:0], cur_code};
      end
   end

   always_comb begin
      case (col_idx)
         2'd0:    col = 4'b1110;
         2'd1:    col = 4'b1101;
         2'd2:    col = 4'b1011;
         default: col = 4'b0111;
      endcase
   end

endmodule

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] number;
   logic [3:0]  key_code;
   logic        key_valid;

   // Keypad model: a pressed key at (kr, kc) pulls row kr low while column kc
   // is driven low. glitch_en overrides the rows directly.
   logic        key_on = 1'b0;
   logic [1:0]  kr = 2'd0;
   logic [1:0]  kc = 2'd0;
   logic        glitch_en = 1'b0;
   logic [3:0]  glitch_val = 4'hF;

   assign row = glitch_en ? glitch_val :
                (key_on && !col[kc]) ? ~(4'b0001 << kr) : 4'hF;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_CNT(32)) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
      .number(number), .key_code(key_code), .key_valid(key_valid)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ev_count = 0;
   logic kv_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Event monitor at the falling edge; main sequence samples 1ns later.
   always @(negedge clk) begin
      if (key_valid) begin
         ev_count++;
         chk("kv_single_cycle", {31'd0, kv_prev}, 32'd0);
      end
      kv_prev = key_valid;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_kv(input int max, output bit got);
      got = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (key_valid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col(input logic [3:0] c, input int max, output bit got);
      got = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (col == c) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic leave_col(input logic [3:0] c);
      for (int i = 0; i < 20 && col == c; i++) tick();
   endtask

   typedef struct {
      logic [1:0]  r;
      logic [1:0]  c;
      logic [3:0]  code;
      logic [15:0] num;
   } vec_t;

   vec_t       vt[9];
   logic [3:0] colpat[4];

   initial begin
      int   ev0, n, trans;
      bit   got, frozen;
      logic [3:0] kcol, ncol, pcol;
      logic [1:0] nc;

      vt[0] = '{2'd0, 2'd0, 4'h1, 16'h0001};
      vt[1] = '{2'd0, 2'd1, 4'h2, 16'h0012};
      vt[2] = '{2'd0, 2'd2, 4'h3, 16'h0123};
      vt[3] = '{2'd0, 2'd3, 4'hA, 16'h123A};
      vt[4] = '{2'd1, 2'd1, 4'h5, 16'h23A5};
      vt[5] = '{2'd2, 2'd1, 4'h8, 16'h3A58};
      vt[6] = '{2'd3, 2'd3, 4'hD, 16'hA58D};
      vt[7] = '{2'd3, 2'd0, 4'h0, 16'h58D0};
      vt[8] = '{2'd1, 2'd2, 4'h6, 16'h8D06};
      colpat[0] = 4'b1110;
      colpat[1] = 4'b1101;
      colpat[2] = 4'b1011;
      colpat[3] = 4'b0111;

      // ---- reset state and idle scan ----
      repeat (3) tick();
      chk("rst_col", col, 4'b1110);
      chk("rst_number", number, 16'h0000);
      chk("rst_key_code", key_code, 4'h0);
      chk("rst_key_valid", key_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         chk("scan_col", col, colpat[(k / 4) % 4]);
      end
      chk("idle_no_event", ev_count, 0);

      // ---- table-driven key presses ----
      for (int i = 0; i < 9; i++) begin
         ev0 = ev_count;
         kr = vt[i].r;
         kc = vt[i].c;
         kcol = ~(4'b0001 << kc);
         nc = kc + 2'd1;
         ncol = ~(4'b0001 << nc);
         key_on = 1'b1;
         wait_kv(200, got);
         chk("kv_seen", got, 1'b1);
         chk("key_code", key_code, vt[i].code);
         chk("number", number, vt[i].num);
         frozen = 1'b1;
         for (int j = 0; j < 20; j++) begin
            tick();
            if (col != kcol) frozen = 1'b0;
         end
         chk("col_frozen", frozen, 1'b1);
         key_on = 1'b0;
         n = 0;
         while (col == kcol && n < 40) begin
            tick();
            n++;
         end
         chk("release_cycles", n, 10);
         chk("next_col", col, ncol);
         chk("one_event", ev_count - ev0, 1);
      end

      // ---- glitch during DEBOUNCE aborts the press (key 6) ----
      ev0 = ev_count;
      kr = 2'd1; kc = 2'd2; kcol = 4'b1011;
      leave_col(kcol);
      key_on = 1'b1;
      wait_col(kcol, 40, got);
      chk("glitch_reach_col", got, 1'b1);
      repeat (6) tick();
      glitch_en = 1'b1;
      glitch_val = 4'b1110;
      repeat (3) tick();
      glitch_en = 1'b0;
      key_on = 1'b0;
      chk("glitch_next_col", col, 4'b0111);
      repeat (30) tick();
      chk("glitch_no_event", ev_count - ev0, 0);
      chk("glitch_number", number, 16'h8D06);

      // ---- two rows low is no key; scanning keeps advancing ----
      ev0 = ev_count;
      glitch_en = 1'b1;
      glitch_val = 4'b1100;
      trans = 0;
      pcol = col;
      for (int j = 0; j < 48; j++) begin
         tick();
         if (col != pcol) trans++;
         pcol = col;
      end
      glitch_en = 1'b0;
      chk("multi_scan_moves", trans >= 11, 1'b1);
      chk("multi_no_event", ev_count - ev0, 0);

      // ---- clear on the event edge of key 9 ----
      kr = 2'd2; kc = 2'd2; kcol = 4'b1011;
      leave_col(kcol);
      key_on = 1'b1;
      wait_col(kcol, 40, got);
      chk("clr_reach_col", got, 1'b1);
      repeat (11) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_key_valid", key_valid, 1'b1);
      chk("clr_number", number, 16'h0000);
      chk("clr_key_code", key_code, 4'h9);
      repeat (5) tick();
      key_on = 1'b0;
      repeat (15) tick();
      chk("clr_number_after", number, 16'h0000);

      // ---- reset mid-DEBOUNCE on key 4, key held through reset ----
      ev0 = ev_count;
      kr = 2'd1; kc = 2'd0; kcol = 4'b1110;
      leave_col(kcol);
      key_on = 1'b1;
      wait_col(kcol, 40, got);
      chk("rstm_reach_col", got, 1'b1);
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("rstm_col", col, 4'b1110);
      chk("rstm_number", number, 16'h0000);
      chk("rstm_key_code", key_code, 4'h0);
      chk("rstm_key_valid", key_valid, 1'b0);
      repeat (3) tick();
      chk("rstm_no_event", ev_count - ev0, 0);
      rst_n = 1'b1;
      wait_kv(200, got);
      chk("rstm_redebounce", got, 1'b1);
      chk("rstm_code", key_code, 4'h4);
      chk("rstm_num", number, 16'h0004);
      key_on = 1'b0;
      repeat (15) tick();
      chk("rstm_one_event", ev_count - ev0, 1);

      // ---- standalone clear, then hold key F ----
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_only", number, 16'h0000);
      ev0 = ev_count;
      kr = 2'd3; kc = 2'd1; kcol = 4'b1101;
      leave_col(kcol);
      key_on = 1'b1;
      wait_kv(200, got);
      chk("hold_seen", got, 1'b1);
      repeat (100) tick();
      key_on = 1'b0;
      repeat (15) tick();
      chk("hold_code", key_code, 4'hF);
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("hold_events", ev_count - ev0, 4);
      chk("hold_number", number, 16'hFFFF);
`else
      chk("hold_events", ev_count - ev0, 1);
      chk("hold_number", number, 16'h000F);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
